cpu_usb_fifo_bridge: RTL

Parametrised successor to the CPU-side USB block. It places independent, depth-configurable RX and TX byte FIFOs between the CPU bus and DMA on one side and a generic valid/ready byte-stream PHY on the other. It adds readable fill levels, sticky overflow and collision flags, and a threshold-driven interrupt. It sits between the CPU bus decoder and the USB PHY (FT1248 or successor) and the DMA engine.

---
 rtl/cpu_usb_fifo_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cpu_usb_fifo_bridge.sv
// CPU/DMA to byte-stream PHY bridge: independent RX/TX first-word-fall-through FIFOs,
// register file (SCR/DATA/LEVEL/THR), sticky error flags and threshold interrupt.
module cpu_usb_fifo_bridge #(
  parameter int unsigned RX_DEPTH_LOG2 = 10,
  parameter int unsigned TX_DEPTH_LOG2 = 10
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        bus_request,
  input  logic [3:2]  bus_address,
  input  logic [3:0]  bus_wmask,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  input  logic        dma_rx_read,
  output logic        dma_rx_empty,
  output logic [7:0]  dma_rx_rdata,
  input  logic        dma_tx_write,
  input  logic [7:0]  dma_tx_wdata,
  output logic        dma_tx_full,
  input  logic        phy_rx_valid,
  input  logic [7:0]  phy_rx_data,
  output logic        phy_rx_ready,
  output logic        phy_tx_valid,
  output logic [7:0]  phy_tx_data,
  input  logic        phy_tx_ready,
  input  logic        phy_pwren,
  output logic        irq
);

  localparam int unsigned RXW      = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TXW      = TX_DEPTH_LOG2 + 1;
  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;

  logic [7:0]               rx_mem [RX_DEPTH];
  logic [7:0]               tx_mem [TX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [RXW-1:0]           rx_count, rx_thr;
  logic [TXW-1:0]           tx_count, tx_thr;

  logic enabled, irq_rx_en, irq_tx_en, rx_overflow, collision;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic scr_wr, thr_wr_lo, thr_wr_hi, cpu_push, cpu_pop;
  logic rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush;
  logic rx_coll, tx_coll, ovf_set;
  logic [7:0]  tx_push_data;
  logic [31:0] read_data;

  assign rx_full  = (rx_count == RXW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == TXW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);

  assign scr_wr    = bus_request && (bus_address == 2'd0) && bus_wmask[0];
  assign cpu_push  = bus_request && (bus_address == 2'd1) && bus_wmask[0];
  assign cpu_pop   = bus_request && (bus_address == 2'd1) && (bus_wmask == 4'b0000);
  assign thr_wr_lo = bus_request && (bus_address == 2'd3) && (bus_wmask[1:0] == 2'b11);
  assign thr_wr_hi = bus_request && (bus_address == 2'd3) && (bus_wmask[3:2] == 2'b11);
  assign rx_flush  = scr_wr && bus_wdata[0];
  assign tx_flush  = scr_wr && bus_wdata[1];

  assign phy_rx_ready = enabled && !rx_full;
  assign phy_tx_valid = enabled && !tx_empty;
  assign dma_rx_empty = rx_empty;
  assign dma_tx_full  = tx_full;
  assign dma_rx_rdata = rx_mem[rx_rd_ptr];
  assign phy_tx_data  = tx_mem[tx_rd_ptr];

  // DMA wins any same-direction clash with a CPU DATA access
  assign rx_coll      = dma_rx_read && cpu_pop;
  assign tx_coll      = dma_tx_write && cpu_push;
  assign rx_push      = phy_rx_valid && phy_rx_ready;
  assign rx_pop       = (dma_rx_read || cpu_pop) && !rx_empty;
  assign tx_pop       = phy_tx_valid && phy_tx_ready;
  assign tx_push      = (dma_tx_write || cpu_push) && (!tx_full || tx_pop);
  assign tx_push_data = dma_tx_write ? dma_tx_wdata : bus_wdata[7:0];
  assign ovf_set      = phy_rx_valid && enabled && rx_full;

  always_ff @(posedge sys_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= phy_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset || rx_flush) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_DEPTH_LOG2'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_DEPTH_LOG2'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RXW'(1);
        2'b01:   rx_count <= rx_count - RXW'(1);
        default: ;
      endcase
    end
  end

  // A push into a full TX FIFO is legal when the PHY drains the head in the same cycle
  always_ff @(posedge sys_clk) begin
    if (sys_reset || tx_flush) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_DEPTH_LOG2'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_DEPTH_LOG2'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TXW'(1);
        2'b01:   tx_count <= tx_count - TXW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    unique case (bus_address)
      2'd0: read_data = {23'd0, collision, phy_pwren, irq, irq_tx_en, irq_rx_en,
                         enabled, rx_overflow, !tx_full, !rx_empty};
      2'd1: if (cpu_pop && !dma_rx_read && !rx_empty) read_data = {24'd0, dma_rx_rdata};
      2'd2: read_data = {16'(tx_count), 16'(rx_count)};
      default: read_data = {16'(tx_thr), 16'(rx_thr)};
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      bus_ack     <= 1'b0;
      bus_rdata   <= '0;
      enabled     <= 1'b0;
      irq_rx_en   <= 1'b0;
      irq_tx_en   <= 1'b0;
      rx_overflow <= 1'b0;
      collision   <= 1'b0;
      rx_thr      <= RXW'(1);
      tx_thr      <= '0;
      irq         <= 1'b0;
    end else begin
      bus_ack   <= bus_request;
      bus_rdata <= bus_request ? read_data : '0;
      if (scr_wr) begin
        enabled   <= bus_wdata[3];
        irq_rx_en <= bus_wdata[4];
        irq_tx_en <= bus_wdata[5];
      end
      // new events win over a same-cycle write-1-to-clear
      rx_overflow <= (rx_overflow && !(scr_wr && bus_wdata[2])) || ovf_set;
      collision   <= (collision && !(scr_wr && bus_wdata[8])) || rx_coll || tx_coll;
      if (thr_wr_lo) rx_thr <= RXW'(bus_wdata[15:0]);
      if (thr_wr_hi) tx_thr <= TXW'(bus_wdata[31:16]);
      irq <= (irq_rx_en && (rx_count >= rx_thr)) || (irq_tx_en && (tx_count <= tx_thr));
    end
  end

endmodule
